// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial add/subtract engine:
// FSM state encodings and the default operand width.
package serial_adder_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial engine.
module serial_adder_ctrl_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full adder sequenced LSB first over WIDTH bits.
// Handshake: start is taken only in IDLE; done pulses one cycle with result valid.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic [1:0]       dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_a_q, sh_a_d;
   logic [WIDTH-1:0] sh_b_q, sh_b_d;
   logic [WIDTH-1:0] sh_r_q, sh_r_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic fa_sum;
   logic fa_cout;

   serial_adder_ctrl_full_adder u_fa (
      .a    (sh_a_q[0]),
      .b    (sh_b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_comb begin
      state_d  = state_q;
      sh_a_d   = sh_a_q;
      sh_b_d   = sh_b_q;
      sh_r_d   = sh_r_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Subtract as a + ~b + 1: the +1 enters through the initial carry.
               state_d = ST_RUN;
               sh_a_d  = op_a;
               sh_b_d  = sub ? ~op_b : op_b;
               sh_r_d  = '0;
               carry_d = sub;
               cnt_d   = '0;
            end
         end

         ST_RUN: begin
            sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
            sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
            sh_r_d  = {fa_sum, sh_r_q[WIDTH-1:1]};
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               // On the MSB, carry_q is the carry into the MSB.
               state_d  = ST_DONE;
               result_d = {fa_sum, sh_r_q[WIDTH-1:1]};
               cout_d   = fa_cout;
               ovf_d    = carry_q ^ fa_cout;
               cnt_d    = '0;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sh_a_q   <= '0;
         sh_b_q   <= '0;
         sh_r_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh_a_q   <= sh_a_d;
         sh_b_q   <= sh_b_d;
         sh_r_q   <= sh_r_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign result    = result_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with hand-computed results.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;
   logic [1:0]   dbg_state;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] prev_result;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sub       (sub),
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .cout      (cout),
      .overflow  (overflow),
      .dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents a one-cycle start pulse; returns #1 after the accepting edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      sub   = s;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts edges after the start edge until done, bounded.
   task automatic wait_done(output int edges, output int busy_n);
      edges  = 0;
      busy_n = 0;
      while (!done && edges < 40) begin
         if (busy) busy_n++;
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] exp_r, input logic exp_c,
                         input logic exp_v);
      int edges;
      int busy_n;
      start_op(a, b, s);
      check({tag, "_busy_start"}, busy, 1);
      check({tag, "_result_hold"}, result, prev_result);
      wait_done(edges, busy_n);
      check({tag, "_latency"}, edges, W);
      check({tag, "_busy_cycles"}, busy_n, W);
      check({tag, "_result"}, result, exp_r);
      check({tag, "_cout"}, cout, exp_c);
      check({tag, "_overflow"}, overflow, exp_v);
      check({tag, "_busy_in_done"}, busy, 0);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_result_after"}, result, exp_r);
      prev_result = exp_r;
   endtask

   initial begin
      int edges;
      int busy_n;
      int done_n;

      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      op_a  = '0;
      op_b  = '0;
      prev_result = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_cout", cout, 0);
      check("rst_overflow", overflow, 0);
      check("rst_state", dbg_state, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op("add",      8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
      run_op("wrap",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("sovf",     8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run_op("sub_brw",  8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
      run_op("sub_ovf",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      run_op("add_mix",  8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);
      run_op("neg_ovf",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      run_op("sub_zero", 8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0);

      // Second start while running at cnt=3 must be ignored.
      start_op(8'h10, 8'h20, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      op_a  = 8'hAA;
      op_b  = 8'h55;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      done_n = 0;
      for (int i = 0; i < 16; i++) begin
         if (done) begin
            done_n++;
            check("hs_result", result, 8'h30);
         end
         @(posedge clk);
         #1;
      end
      check("hs_done_count", done_n, 1);
      check("hs_busy_after", busy, 0);
      prev_result = 8'h30;

      // Start asserted during the done cycle is dropped.
      start_op(8'h01, 8'h02, 1'b0);
      wait_done(edges, busy_n);
      check("dc_latency", edges, W);
      check("dc_result", result, 8'h03);
      op_a  = 8'h44;
      op_b  = 8'h11;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("dc_state_idle", dbg_state, 0);
      done_n = 0;
      busy_n = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (busy) busy_n++;
         if (done) done_n++;
      end
      check("dc_no_busy", busy_n, 0);
      check("dc_no_done", done_n, 0);
      check("dc_result_hold", result, 8'h03);
      prev_result = 8'h03;

      // Reset at cnt=4 aborts with no done pulse.
      start_op(8'h3C, 8'h05, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_result", result, 0);
      check("mid_rst_state", dbg_state, 0);
      done_n = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) done_n++;
      end
      check("mid_rst_no_done", done_n, 0);
      prev_result = '0;
      run_op("post_rst", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);

      // Reset and start together: reset wins.
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      op_a  = 8'h12;
      op_b  = 8'h34;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      check("rs_busy", busy, 0);
      check("rs_result", result, 0);
      done_n = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) done_n++;
      end
      check("rs_no_activity", done_n, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
